// File: rtl/pow2_pkg.sv
// Shared constants, the 2^f mantissa table and the fp32 packing helper for the pow2 datapath.
package pow2_pkg;

  localparam int          FP_EXP_BIAS   = 127;
  localparam logic [31:0] FP_POS_INF    = 32'h7F80_0000;
  localparam logic [31:0] FP_ZERO       = 32'h0000_0000;
  localparam int          LUT_FULL_BITS = 8;
  localparam int          LUT_FULL_SIZE = (1 << LUT_FULL_BITS) + 1;

  // Entries carry 25 bits so the 2^24 end point is representable.
  typedef logic [LUT_FULL_SIZE-1:0][24:0] pow2_lut_t;

  function automatic logic [63:0] isqrt128(input logic [127:0] v);
    logic [63:0]  res;
    logic [63:0]  t;
    logic [127:0] sq;
    res = '0;
    for (int b = 63; b >= 0; b--) begin
      t  = res | (64'd1 << b);
      sq = {64'd0, t} * {64'd0, t};
      if (sq <= v) res = t;
    end
    return res;
  endfunction

  // root[b] = 2^(2^b/256) in Q2.62; entry j is the product of the roots selected by j's bits.
  function automatic pow2_lut_t pow2_lut_gen();
    pow2_lut_t           tbl;
    logic [7:0][63:0]    root;
    logic [127:0]        acc;
    tbl     = '0;
    root[7] = isqrt128(128'd1 << 125);
    for (int b = 6; b >= 0; b--) begin
      root[b] = isqrt128({64'd0, root[b+1]} << 62);
    end
    for (int j = 0; j < LUT_FULL_SIZE - 1; j++) begin
      acc = 128'd1 << 62;
      for (int b = 0; b < LUT_FULL_BITS; b++) begin
        if (j[b]) acc = (acc * {64'd0, root[b]}) >> 62;
      end
      tbl[j] = 25'((acc + (128'd1 << 38)) >> 39);
    end
    tbl[LUT_FULL_SIZE-1] = 25'h100_0000;
    return tbl;
  endfunction

  localparam pow2_lut_t POW2_LUT256 = pow2_lut_gen();

  function automatic logic [31:0] fp32_pack(input logic [7:0] e, input logic [23:0] m24);
    return {1'b0, e, m24[22:0]};
  endfunction

endpackage

// File: rtl/pow2_lut.sv
// Combinational read of the 2^f mantissa table decimated to 2^LUT_BITS segments.
// With POW2_INTERP_EN the upper segment end point T[k+1] is also returned.
module pow2_lut
  import pow2_pkg::*;
#(
  parameter int LUT_BITS = 4
) (
  input  logic [LUT_BITS-1:0] k,
  output logic [23:0]         t_lo
`ifdef POW2_INTERP_EN
  ,
  output logic [24:0]         t_hi
`endif
);

  localparam int SHIFT = LUT_FULL_BITS - LUT_BITS;

  logic [8:0] idx_lo;

  assign idx_lo = 9'(k) << SHIFT;
  assign t_lo   = 24'(POW2_LUT256[idx_lo]);

`ifdef POW2_INTERP_EN
  logic [8:0] idx_hi;

  assign idx_hi = idx_lo + (9'd1 << SHIFT);
  assign t_hi   = POW2_LUT256[idx_hi];
`endif

endmodule

// File: rtl/pow2_fp_pipe.sv
// Two-stage valid/ready pipeline producing IEEE-754 single 2^x for a signed fixed-point x.
// Define POW2_INTERP_EN to interpolate linearly between table entries instead of truncating.
module pow2_fp_pipe #(
  parameter int IN_WIDTH  = 16,
  parameter int FRAC_BITS = 8,
  parameter int LUT_BITS  = 4
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic [IN_WIDTH-1:0] Datain,
  input  logic                Datain_vld,
  output logic                Datain_rdy,
  output logic [31:0]         DataOut,
  output logic                DataOut_vld,
  input  logic                DataOut_rdy,
  output logic                DataOut_ovf,
  output logic                DataOut_udf
);
  import pow2_pkg::*;

  localparam int INT_W = IN_WIDTH - FRAC_BITS;
  // Biased exponent needs headroom for both the bias and the full integer range.
  localparam int EXP_W = (INT_W + 2 > 10) ? INT_W + 2 : 10;
  localparam int RW    = FRAC_BITS - LUT_BITS;

  if (LUT_BITS > FRAC_BITS || LUT_BITS < 2 || LUT_BITS > 8) begin : g_bad_cfg
    $error("pow2_fp_pipe: LUT_BITS=%0d invalid for FRAC_BITS=%0d", LUT_BITS, FRAC_BITS);
  end

  logic [LUT_BITS-1:0] k_in;
  logic [EXP_W-1:0]    e_in;
  logic [23:0]         tlo_in;

  assign k_in = Datain[FRAC_BITS-1 -: LUT_BITS];
  assign e_in = {{(EXP_W-INT_W){Datain[IN_WIDTH-1]}}, Datain[IN_WIDTH-1:FRAC_BITS]}
              + EXP_W'(FP_EXP_BIAS);

`ifdef POW2_INTERP_EN
  localparam int RW_W = (RW > 0) ? RW : 1;

  logic [24:0]     thi_in;
  logic [RW_W-1:0] r_in;

  if (RW > 0) begin : g_r
    assign r_in = Datain[RW-1:0];
  end else begin : g_no_r
    assign r_in = '0;
  end

  pow2_lut #(.LUT_BITS(LUT_BITS)) u_lut (
    .k    (k_in),
    .t_lo (tlo_in),
    .t_hi (thi_in)
  );
`else
  if (RW > 0) begin : g_r_drop
    logic r_unused;
    assign r_unused = ^Datain[RW-1:0];
  end

  pow2_lut #(.LUT_BITS(LUT_BITS)) u_lut (
    .k    (k_in),
    .t_lo (tlo_in)
  );
`endif

  logic             s1_vld_q, s1_vld_d;
  logic [EXP_W-1:0] s1_e_q, s1_e_d;
  logic [23:0]      s1_tlo_q, s1_tlo_d;
`ifdef POW2_INTERP_EN
  logic [24:0]      s1_thi_q, s1_thi_d;
  logic [RW_W-1:0]  s1_r_q, s1_r_d;
`endif
  logic [31:0]      dout_q, dout_d;
  logic             dout_vld_q, dout_vld_d;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;

  logic        s2_load;
  logic        s1_adv;
  logic        in_fire;
  logic        e_ovf;
  logic        e_udf;
  logic [23:0] m24;

`ifdef POW2_INTERP_EN
  logic [24:0]             seg_diff;
  logic [24+FRAC_BITS-1:0] seg_prod;

  assign seg_diff = s1_thi_q - {1'b0, s1_tlo_q};
  assign seg_prod = (24+FRAC_BITS)'(seg_diff) * (24+FRAC_BITS)'(s1_r_q);
  assign m24      = s1_tlo_q + 24'(seg_prod >> RW);
`else
  assign m24 = s1_tlo_q;
`endif

  always_comb begin
    s2_load = !dout_vld_q || DataOut_rdy;
    s1_adv  = !s1_vld_q || s2_load;
    in_fire = Datain_vld && s1_adv;

    s1_vld_d = s1_vld_q;
    s1_e_d   = s1_e_q;
    s1_tlo_d = s1_tlo_q;
`ifdef POW2_INTERP_EN
    s1_thi_d = s1_thi_q;
    s1_r_d   = s1_r_q;
`endif
    if (s1_adv) s1_vld_d = Datain_vld;
    if (in_fire) begin
      s1_e_d   = e_in;
      s1_tlo_d = tlo_in;
`ifdef POW2_INTERP_EN
      s1_thi_d = thi_in;
      s1_r_d   = r_in;
`endif
    end

    // e is two's complement; a set top bit means a negative biased exponent.
    e_ovf = !s1_e_q[EXP_W-1] && (s1_e_q >= EXP_W'(255));
    e_udf = s1_e_q[EXP_W-1] || (s1_e_q == '0);

    dout_vld_d = dout_vld_q;
    dout_d     = dout_q;
    ovf_d      = ovf_q;
    udf_d      = udf_q;
    if (s2_load) begin
      dout_vld_d = s1_vld_q;
      if (s1_vld_q) begin
        ovf_d = e_ovf;
        udf_d = e_udf;
        if (e_ovf)      dout_d = FP_POS_INF;
        else if (e_udf) dout_d = FP_ZERO;
        else            dout_d = fp32_pack(s1_e_q[7:0], m24);
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      s1_vld_q   <= 1'b0;
      s1_e_q     <= '0;
      s1_tlo_q   <= '0;
`ifdef POW2_INTERP_EN
      s1_thi_q   <= '0;
      s1_r_q     <= '0;
`endif
      dout_q     <= FP_ZERO;
      dout_vld_q <= 1'b0;
      ovf_q      <= 1'b0;
      udf_q      <= 1'b0;
    end else begin
      s1_vld_q   <= s1_vld_d;
      s1_e_q     <= s1_e_d;
      s1_tlo_q   <= s1_tlo_d;
`ifdef POW2_INTERP_EN
      s1_thi_q   <= s1_thi_d;
      s1_r_q     <= s1_r_d;
`endif
      dout_q     <= dout_d;
      dout_vld_q <= dout_vld_d;
      ovf_q      <= ovf_d;
      udf_q      <= udf_d;
    end
  end

  assign Datain_rdy  = s1_adv;
  assign DataOut     = dout_q;
  assign DataOut_vld = dout_vld_q;
  assign DataOut_ovf = ovf_q;
  assign DataOut_udf = udf_q;

endmodule

// File: tb/tb_pow2_fp_pipe.sv
// Directed bench for pow2_fp_pipe: default 16-bit instance plus a 20-bit instance for overflow.
// Expected values follow POW2_INTERP_EN when it is defined for the build.
module tb_pow2_fp_pipe;

  logic        Clock = 1'b0;
  logic        Reset;
  logic [15:0] Datain;
  logic        Datain_vld;
  logic        Datain_rdy;
  logic [31:0] DataOut;
  logic        DataOut_vld;
  logic        DataOut_rdy;
  logic        DataOut_ovf;
  logic        DataOut_udf;

  logic [19:0] w_datain;
  logic        w_vld;
  logic        w_rdy;
  logic [31:0] w_dout;
  logic        w_dout_vld;
  logic        w_dout_rdy;
  logic        w_ovf;
  logic        w_udf;

  int checks = 0;
  int errors = 0;

  always #5 Clock = ~Clock;

  pow2_fp_pipe u_dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .Datain      (Datain),
    .Datain_vld  (Datain_vld),
    .Datain_rdy  (Datain_rdy),
    .DataOut     (DataOut),
    .DataOut_vld (DataOut_vld),
    .DataOut_rdy (DataOut_rdy),
    .DataOut_ovf (DataOut_ovf),
    .DataOut_udf (DataOut_udf)
  );

  pow2_fp_pipe #(.IN_WIDTH(20), .FRAC_BITS(8), .LUT_BITS(4)) u_dut20 (
    .Clock       (Clock),
    .Reset       (Reset),
    .Datain      (w_datain),
    .Datain_vld  (w_vld),
    .Datain_rdy  (w_rdy),
    .DataOut     (w_dout),
    .DataOut_vld (w_dout_vld),
    .DataOut_rdy (w_dout_rdy),
    .DataOut_ovf (w_ovf),
    .DataOut_udf (w_udf)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Present one input, then confirm nothing at +1 cycle and the result at +2 cycles.
  task automatic run_one(input string tag, input bit wide, input logic [19:0] x,
                         input logic [31:0] exp, input logic e_ovf, input logic e_udf);
    @(negedge Clock);
    if (wide) begin
      w_datain = x;
      w_vld    = 1'b1;
    end else begin
      Datain     = x[15:0];
      Datain_vld = 1'b1;
    end
    #1;
    check({tag, "_rdy"}, 32'(wide ? w_rdy : Datain_rdy), 32'd1);
    @(negedge Clock);
    Datain_vld = 1'b0;
    w_vld      = 1'b0;
    check({tag, "_vld_c1"}, 32'(wide ? w_dout_vld : DataOut_vld), 32'd0);
    @(negedge Clock);
    check({tag, "_vld_c2"}, 32'(wide ? w_dout_vld : DataOut_vld), 32'd1);
    check({tag, "_data"},   wide ? w_dout : DataOut, exp);
    check({tag, "_ovf"},    32'(wide ? w_ovf : DataOut_ovf), 32'(e_ovf));
    check({tag, "_udf"},    32'(wide ? w_udf : DataOut_udf), 32'(e_udf));
  endtask

  function automatic logic [15:0] bp_x(input int n);
    int v;
    v = n * 7 - 30;
    return 16'(v * 256);
  endfunction

  function automatic logic [31:0] bp_exp(input int n);
    int v;
    v = n * 7 - 30;
    return 32'(127 + v) << 23;
  endfunction

  logic [31:0] exp_q[$];
  logic [31:0] held;
  logic        stalled;
  logic        exp_rdy;
  int          occ;
  int          sent;
  int          got;

  initial begin
    Reset       = 1'b1;
    Datain      = '0;
    Datain_vld  = 1'b0;
    DataOut_rdy = 1'b1;
    w_datain    = '0;
    w_vld       = 1'b0;
    w_dout_rdy  = 1'b1;

    repeat (3) @(negedge Clock);
    check("rst_data", DataOut, 32'h0);
    check("rst_vld",  32'(DataOut_vld), 32'd0);
    check("rst_ovf",  32'(DataOut_ovf), 32'd0);
    check("rst_udf",  32'(DataOut_udf), 32'd0);
    Reset = 1'b0;
    #1;
    check("rst_rdy",    32'(Datain_rdy), 32'd1);
    check("rst_rdy_w",  32'(w_rdy), 32'd1);

    run_one("x_0",      0, 20'h00000, 32'h3F80_0000, 1'b0, 1'b0);
    run_one("x_3",      0, 20'h00300, 32'h4100_0000, 1'b0, 1'b0);
    run_one("x_m1",     0, 20'h0FF00, 32'h3F00_0000, 1'b0, 1'b0);
    run_one("x_0p5",    0, 20'h00080, 32'h3FB5_04F3, 1'b0, 1'b0);
    run_one("x_0p25",   0, 20'h00040, 32'h3F98_37F0, 1'b0, 1'b0);
    run_one("x_0p75",   0, 20'h000C0, 32'h3FD7_44FD, 1'b0, 1'b0);
    run_one("x_m0p5",   0, 20'h0FF80, 32'h3F35_04F3, 1'b0, 1'b0);
`ifdef POW2_INTERP_EN
    run_one("x_0p53",   0, 20'h00088, 32'h3FB9_06CB, 1'b0, 1'b0);
`else
    run_one("x_0p53",   0, 20'h00088, 32'h3FB5_04F3, 1'b0, 1'b0);
`endif
    run_one("x_m127",   0, 20'h08100, 32'h0000_0000, 1'b0, 1'b1);
    run_one("x_m128",   0, 20'h08000, 32'h0000_0000, 1'b0, 1'b1);
    run_one("x_m126",   0, 20'h08200, 32'h0080_0000, 1'b0, 1'b0);
    run_one("x_127",    0, 20'h07F00, 32'h7F00_0000, 1'b0, 1'b0);

    run_one("w_128",    1, 20'h08000, 32'h7F80_0000, 1'b1, 1'b0);
    run_one("w_127",    1, 20'h07F00, 32'h7F00_0000, 1'b0, 1'b0);
    run_one("w_m126",   1, 20'hF8200, 32'h0080_0000, 1'b0, 1'b0);
    run_one("w_m127",   1, 20'hF8100, 32'h0000_0000, 1'b0, 1'b1);
    run_one("w_m200",   1, 20'hF3800, 32'h0000_0000, 1'b0, 1'b1);

    // Backpressure: 10 back-to-back inputs against a random DataOut_rdy pattern.
    occ     = 0;
    sent    = 0;
    got     = 0;
    stalled = 1'b0;
    held    = '0;
    for (int cyc = 0; cyc < 300 && got < 10; cyc++) begin
      @(negedge Clock);
      if (stalled) begin
        check("bp_hold_data", DataOut, held);
        check("bp_hold_vld",  32'(DataOut_vld), 32'd1);
      end
      DataOut_rdy = 1'($urandom_range(0, 1));
      Datain_vld  = (sent < 10);
      Datain      = bp_x(sent);
      #1;
      exp_rdy = !(occ == 2 && !DataOut_rdy);
      check("bp_rdy", 32'(Datain_rdy), 32'(exp_rdy));
      if (DataOut_vld && DataOut_rdy) begin
        if (exp_q.size() == 0) begin
          check("bp_extra_out", 32'd1, 32'd0);
        end else begin
          check("bp_data", DataOut, exp_q.pop_front());
        end
        got++;
        occ--;
      end
      stalled = DataOut_vld && !DataOut_rdy;
      held    = DataOut;
      if (Datain_vld && Datain_rdy) begin
        exp_q.push_back(bp_exp(sent));
        sent++;
        occ++;
      end
    end
    Datain_vld  = 1'b0;
    DataOut_rdy = 1'b1;
    check("bp_count", 32'(got), 32'd10);
    check("bp_left",  32'(exp_q.size()), 32'd0);
    @(negedge Clock);
    check("bp_drained", 32'(DataOut_vld), 32'd0);

    // Reset with two items in flight discards both.
    @(negedge Clock);
    Datain     = 16'h0200;
    Datain_vld = 1'b1;
    @(negedge Clock);
    Datain     = 16'h0400;
    @(negedge Clock);
    Datain_vld = 1'b0;
    check("inflight_vld", 32'(DataOut_vld), 32'd1);
    Reset = 1'b1;
    @(negedge Clock);
    check("mid_rst_vld",  32'(DataOut_vld), 32'd0);
    check("mid_rst_data", DataOut, 32'h0);
    check("mid_rst_ovf",  32'(DataOut_ovf), 32'd0);
    check("mid_rst_udf",  32'(DataOut_udf), 32'd0);
    Reset = 1'b0;
    #1;
    check("post_rst_rdy", 32'(Datain_rdy), 32'd1);
    @(negedge Clock);
    check("post_rst_empty", 32'(DataOut_vld), 32'd0);
    run_one("post_rst", 0, 20'h00100, 32'h4000_0000, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
